multicycle_controller: RTL

Multi-cycle MIPS control unit: a Moore/Mealy FSM that sequences a shared-memory, single-ALU datapath through fetch, decode, execute, memory and write-back steps. It sits beside the datapath and reads the opcode from the datapath's instruction register. It drives every mux select and write enable, including PC, IR, register file and memory. Supported instructions: R-type, lw, sw, beq, j, addi; every other opcode takes a trap path.

---
 rtl/mips_ctrl_pkg.sv | 98 +++++++++
 rtl/multicycle_ctrl_decode.sv | 117 +++++++++++
 rtl/multicycle_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// opcodes, datapath select encodings and the bundled control word.
package mips_ctrl_pkg;

    // State encodings (debug-visible on the State port)
    localparam logic [3:0] ST_FETCH   = 4'd0;
    localparam logic [3:0] ST_DECODE  = 4'd1;
    localparam logic [3:0] ST_MEMADR  = 4'd2;
    localparam logic [3:0] ST_MEMRD   = 4'd3;
    localparam logic [3:0] ST_MEMWB   = 4'd4;
    localparam logic [3:0] ST_MEMWR   = 4'd5;
    localparam logic [3:0] ST_EXEC    = 4'd6;
    localparam logic [3:0] ST_RWB     = 4'd7;
    localparam logic [3:0] ST_BRANCH  = 4'd8;
    localparam logic [3:0] ST_JUMP    = 4'd9;
    localparam logic [3:0] ST_ADDIEX  = 4'd10;
    localparam logic [3:0] ST_ADDIWB  = 4'd11;
    localparam logic [3:0] ST_ILLEGAL = 4'd12;

    typedef enum logic [3:0] {
        FETCH   = ST_FETCH,
        DECODE  = ST_DECODE,
        MEMADR  = ST_MEMADR,
        MEMRD   = ST_MEMRD,
        MEMWB   = ST_MEMWB,
        MEMWR   = ST_MEMWR,
        EXEC    = ST_EXEC,
        RWB     = ST_RWB,
        BRANCH  = ST_BRANCH,
        JUMP    = ST_JUMP,
        ADDIEX  = ST_ADDIEX,
        ADDIWB  = ST_ADDIWB,
        ILLEGAL = ST_ILLEGAL
    } state_e;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Every control output of the unit, bundled for the decode stage
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
        logic       instr_done;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    // Control word with every enable and select at its inactive value
    localparam ctrl_t CTRL_IDLE = '0;

    // Successor of DECODE for a given opcode; unsupported opcodes trap
    function automatic state_e dispatch(input logic [5:0] opcode);
        state_e nxt;
        case (opcode)
            OP_RTYPE: nxt = EXEC;
            OP_LW:    nxt = MEMADR;
            OP_SW:    nxt = MEMADR;
            OP_BEQ:   nxt = BRANCH;
            OP_J:     nxt = JUMP;
            OP_ADDI:  nxt = ADDIEX;
            default:  nxt = ILLEGAL;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Combinational output decode: current state plus the MemReady/ALUZero
// handshakes map to the full datapath control word.
module multicycle_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]        state,
    input  logic              mem_ready,
    input  logic              alu_zero,
    output logic [CTRL_W-1:0] ctrl_bits
);

    ctrl_t ctrl_s;

    assign ctrl_bits = ctrl_s;

    // Per-state control word; unlisted fields stay at their idle value
    always_comb begin
        ctrl_s = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.iord      = 1'b0;
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = SRCB_FOUR;
                ctrl_s.alu_op    = ALUOP_ADD;
                ctrl_s.pc_source = PCSRC_ALU;
                // IR and PC latch only when the instruction word arrives
                if (mem_ready) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                end else begin
                    ctrl_s.ir_write = 1'b0;
                    ctrl_s.pc_write = 1'b0;
                end
            end
            ST_DECODE: begin
                // Speculative branch target: PC + (imm << 2)
                ctrl_s.alu_src_a = 1'b0;
                ctrl_s.alu_src_b = SRCB_IMM_SH;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_s.reg_dst    = 1'b0;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_s.mem_write = 1'b1;
                ctrl_s.iord      = 1'b1;
                // Store retires in the cycle the memory accepts it
                if (mem_ready) begin
                    ctrl_s.instr_done = 1'b1;
                end else begin
                    ctrl_s.instr_done = 1'b0;
                end
            end
            ST_EXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_B;
                ctrl_s.alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.mem_to_reg = 1'b0;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_s.alu_src_a  = 1'b1;
                ctrl_s.alu_src_b  = SRCB_B;
                ctrl_s.alu_op     = ALUOP_SUB;
                ctrl_s.pc_source  = PCSRC_ALUOUT;
                ctrl_s.instr_done = 1'b1;
                // Taken only when the operands compare equal
                if (alu_zero) begin
                    ctrl_s.pc_write = 1'b1;
                end else begin
                    ctrl_s.pc_write = 1'b0;
                end
            end
            ST_JUMP: begin
                ctrl_s.pc_source  = PCSRC_JUMP;
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            ST_ADDIEX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
                ctrl_s.alu_op    = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl_s.reg_dst    = 1'b0;
                ctrl_s.mem_to_reg = 1'b0;
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            ST_ILLEGAL: begin
                ctrl_s.illegal = 1'b1;
            end
            default: begin
                // Unreachable encodings drive nothing
                ctrl_s = CTRL_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control unit: state register and next-state logic;
// output decoding lives in multicycle_ctrl_decode.
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [5:0] Opcode,
    input  logic       ALUZero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       Illegal,
    output logic       InstrDone,
    output logic [3:0] State
);

    state_e            state_r;
    state_e            state_next_s;
    logic [CTRL_W-1:0] ctrl_bits_s;
    ctrl_t             ctrl_s;

    // State register; reset is asynchronous so an in-flight access is abandoned at once
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; memory states hold until the access completes
    always_comb begin
        state_next_s = FETCH;
        case (state_r)
            FETCH: begin
                if (MemReady) begin
                    state_next_s = DECODE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            DECODE: begin
                state_next_s = dispatch(Opcode);
            end
            MEMADR: begin
                if (Opcode == OP_LW) begin
                    state_next_s = MEMRD;
                end else begin
                    state_next_s = MEMWR;
                end
            end
            MEMRD: begin
                if (MemReady) begin
                    state_next_s = MEMWB;
                end else begin
                    state_next_s = MEMRD;
                end
            end
            MEMWR: begin
                if (MemReady) begin
                    state_next_s = FETCH;
                end else begin
                    state_next_s = MEMWR;
                end
            end
            EXEC:    state_next_s = RWB;
            ADDIEX:  state_next_s = ADDIWB;
            MEMWB:   state_next_s = FETCH;
            RWB:     state_next_s = FETCH;
            BRANCH:  state_next_s = FETCH;
            JUMP:    state_next_s = FETCH;
            ADDIWB:  state_next_s = FETCH;
            ILLEGAL: state_next_s = FETCH;
            default: state_next_s = FETCH;
        endcase
    end

    multicycle_ctrl_decode u_decode (
        .state     (state_r),
        .mem_ready (MemReady),
        .alu_zero  (ALUZero),
        .ctrl_bits (ctrl_bits_s)
    );

    assign ctrl_s = ctrl_t'(ctrl_bits_s);

    // Port drive; architectural writes are suppressed while reset is held
    always_comb begin
        MemRead   = ctrl_s.mem_read;
        IorD      = ctrl_s.iord;
        RegDst    = ctrl_s.reg_dst;
        MemtoReg  = ctrl_s.mem_to_reg;
        ALUSrcA   = ctrl_s.alu_src_a;
        ALUSrcB   = ctrl_s.alu_src_b;
        ALUOp     = ctrl_s.alu_op;
        PCSource  = ctrl_s.pc_source;
        Illegal   = ctrl_s.illegal;
        InstrDone = ctrl_s.instr_done;
        if (Rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            State    = 4'd0;
        end else begin
            PCWrite  = ctrl_s.pc_write;
            IRWrite  = ctrl_s.ir_write;
            RegWrite = ctrl_s.reg_write;
            MemWrite = ctrl_s.mem_write;
            State    = state_r;
        end
    end

endmodule
